dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the pipeline's data memory port: accepts one load/store request at a time over a valid/ready channel, performs the access after a fixed latency and returns the result over a valid/ready response channel. It replaces the zero-latency combinational data memory behind the memory stage, and lets the core run against slower, stall-capable memory. Sub-word stores use byte lanes; sub-word loads are sign- or zero-extended.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two, at least 4
- LATENCY, 2, clock edges from request acceptance to response valid; 1 to 15
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; word index = req_addr[log2(DEPTH)+1:2], upper bits ignored (wrap modulo DEPTH)
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load only: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data; the value sits in the low bits for byte/half
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned access or reserved size; the access is not performed

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch we, addr, size, unsigned and wdata. Load the latency counter with LATENCY-1. Go to ACCESS.
- ACCESS: if the counter is 0, perform the access and go to RESP; otherwise decrement the counter.
- Performing the access:
  - Compute err: size 11; half with addr[0]=1; word with addr[1:0]≠0.
  - Store without err: write byte lanes. Byte: lane addr[1:0]. Half: lanes addr[1]*2 and addr[1]*2+1. Word: all lanes. Data is replicated into the addressed lanes.
  - Load without err: select the byte or half by addr[1:0], then extend per unsigned.
  - err or store: rsp_rdata=0.
  - Latch rsp_rdata and rsp_err into output registers.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready. When rsp_ready is high, go to IDLE.
- No pipelining: at most one request is outstanding. Requests arriving while req_ready=0 are ignored, not queued.
- Reset:
  - Outputs on reset: req_ready=0 while rst is high, then 1 in IDLE; rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - Storage contents are not reset and survive rst.
  - Reset mid-operation (in ACCESS or RESP) discards the request. A pending store that has not yet reached its commit edge is dropped.

## Timing
- Request accepted at edge E0, when req_valid && req_ready.
- Store commit and rsp_valid rise both happen at edge E0+LATENCY.
- If rsp_ready is high in the first RESP cycle, rsp_valid falls at E0+LATENCY+1 and req_ready rises at that same edge.
- Minimum request spacing is LATENCY+2 edges.
- Back-pressure: rsp_ready low holds RESP indefinitely. Outputs stay frozen and req_ready stays 0.
- Storage read is combinational from the array, sampled at the commit edge. A store and a load never overlap, so there is no read-during-write hazard.
- The request payload is sampled only at the acceptance edge. Later changes on req_* have no effect.

## Structure
- Package dmem_pkg holds:
  - size encodings SIZE_B, SIZE_H, SIZE_W;
  - state enum {IDLE, ACCESS, RESP};
  - a function computing the 4-bit byte enable and the err flag from size and addr[1:0].
- Sub-module dmem_array holds DEPTH×32 storage with a 4-bit byte-enable synchronous write and an asynchronous word read. It has no reset.
- Top level holds the FSM, latency counter, request latch, load extension and output registers.

## Test plan
- LATENCY=2: store word 0xDEADBEEF at 0x10, then load word at 0x10 → rsp_valid exactly 2 edges after each acceptance; rdata=0xDEADBEEF; err=0.
- Store byte 0x80 at 0x13:
  - a signed byte load at 0x13 returns 0xFFFFFF80;
  - an unsigned byte load returns 0x00000080;
  - a word load at 0x10 returns 0x80ADBEEF.
- Half store at 0x11 → err=1, rdata=0, and memory is unchanged (a word load at 0x10 still returns 0x80ADBEEF). A load with size 11 also returns err=1.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rdata and err stay stable, req_ready=0, and a concurrent req_valid is ignored. Releasing rsp_ready gives req_ready=1 on the next edge.
- Assert rst during ACCESS of a store of 0x12345678 to 0x20 → outputs go to their reset values immediately, and a later load of 0x20 returns the old contents.
- Address wrap: with DEPTH=1024, a word store at 0x1004 is read back by a word load at 0x0004.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and lane/err decode for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef struct packed {
        logic [3:0] be;
        logic       err;
    } lane_sel_t;

    // Misaligned or reserved-size accesses get err and an empty byte enable.
    function automatic lane_sel_t lane_sel(input logic [1:0] size, input logic [1:0] off);
        lane_sel_t r;
        r.be  = 4'b0000;
        r.err = 1'b0;
        case (size)
            SIZE_B: r.be = 4'b0001 << off;
            SIZE_H: begin
                r.err = off[0];
                r.be  = off[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_W: begin
                r.err = (off != 2'b00);
                r.be  = 4'b1111;
            end
            default: r.err = 1'b1;
        endcase
        if (r.err) r.be = 4'b0000;
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: byte-enable synchronous write, asynchronous word read, no reset.
module dmem_array #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder: one request in flight, valid/ready on both sides.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, uns_q;
    logic [1:0]      size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            latch_req, commit;
    lane_sel_t       sel;
    logic [31:0]     mem_rdata, wdata_rep, ld_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];
    assign sel         = lane_sel(size_q, addr_q[1:0]);

    always_comb begin
        wdata_rep = wdata_q;
        case (size_q)
            SIZE_B:  wdata_rep = {4{wdata_q[7:0]}};
            SIZE_H:  wdata_rep = {2{wdata_q[15:0]}};
            default: wdata_rep = wdata_q;
        endcase
    end

    assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = mem_rdata;
        case (size_q)
            SIZE_B:  ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            SIZE_H:  ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // rst gates the write so a store whose commit edge coincides with reset is dropped.
    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (commit & we_q & ~sel.err & ~rst),
        .be    (sel.be),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_rep),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        latch_req = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    latch_req = 1'b1;
                    cnt_d     = 4'(LATENCY - 1);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    err_d   = sel.err;
                    rdata_d = (sel.err || we_q) ? 32'd0 : ld_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (latch_req) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    assign req_ready = (state_q == IDLE) & ~rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-level memory model plus a per-cycle output compare.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic        chk_en = 1'b0;
    logic        chk_data = 1'b0;
    logic        exp_ready, exp_valid, exp_err;
    logic [31:0] exp_rdata;

    // Byte-addressed reference memory (DEPTH*4 bytes, address wraps modulo its size).
    logic [7:0] mb [DEPTH*4];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            if (chk_data) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            end
        end
    end

    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd, input bit do_commit,
                         output logic err, output logic [31:0] rd);
        int n;
        int base;
        logic [31:0] v;
        n    = 1 << size;
        base = int'(addr % (DEPTH*4));
        err  = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        rd   = 32'd0;
        v    = 32'd0;
        if (!err && we && do_commit)
            for (int i = 0; i < n; i++) mb[base+i] = wd[8*i +: 8];
        if (!err && !we) begin
            for (int i = 0; i < n; i++) v = v | (32'(mb[base+i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input int hold, input bit rst_mid,
                       output logic [31:0] m_rd, output logic m_err, output logic [31:0] d_rd);
        model(we, addr, size, uns, wd, !rst_mid, m_err, m_rd);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_size = 2'($urandom);
        req_unsigned = ~uns; req_wdata = $urandom;
        exp_ready = 1'b0; exp_valid = 1'b0; chk_data = 1'b0;
        d_rd = 32'd0;
        if (rst_mid) begin
            rst = 1'b1;
            exp_rdata = 32'd0; exp_err = 1'b0; chk_data = 1'b1;
            repeat (LAT + 1) @(posedge clk);
            #1;
            rst = 1'b0; exp_ready = 1'b1; chk_data = 1'b0;
            return;
        end
        repeat (LAT - 1) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        exp_valid = 1'b1; exp_rdata = m_rd; exp_err = m_err; chk_data = 1'b1;
        d_rd = rsp_rdata;
        if (hold > 0) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            repeat (hold) begin @(posedge clk); #1; end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; exp_valid = 1'b0; exp_ready = 1'b1; chk_data = 1'b0;
    endtask

    initial begin
        logic [31:0] m_rd, d_rd;
        logic        m_err;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b0;
        #1 rst = 1'b1;
        exp_ready = 1'b0; exp_valid = 1'b0; exp_rdata = 32'd0; exp_err = 1'b0;
        chk_data = 1'b1; chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; exp_ready = 1'b1; chk_data = 1'b0;
        @(posedge clk); #1;

        txn(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 0, m_rd, m_err, d_rd);
        txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_word_ld", d_rd, 32'hDEAD_BEEF);
        check("lit_word_model", m_rd, 32'hDEAD_BEEF);

        txn(1'b1, 32'h13, 2'b00, 1'b0, 32'h5555_5580, 0, 0, m_rd, m_err, d_rd);
        txn(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_sbyte", d_rd, 32'hFFFF_FF80);
        txn(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_ubyte", d_rd, 32'h0000_0080);
        txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_word_after_byte", d_rd, 32'h80AD_BEEF);

        txn(1'b1, 32'h11, 2'b01, 1'b0, 32'h0000_1234, 0, 0, m_rd, m_err, d_rd);
        check("lit_misaligned_err", {31'd0, m_err}, 32'd1);
        txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_mem_unchanged", d_rd, 32'h80AD_BEEF);
        txn(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_reserved_err", {31'd0, m_err}, 32'd1);

        txn(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 5, 0, m_rd, m_err, d_rd);
        check("lit_shalf_held", d_rd, 32'hFFFF_80AD);

        txn(1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFE_F00D, 0, 0, m_rd, m_err, d_rd);
        txn(1'b1, 32'h20, 2'b10, 1'b0, 32'h1234_5678, 0, 1, m_rd, m_err, d_rd);
        @(posedge clk); #1;
        txn(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_rst_drops_store", d_rd, 32'hCAFE_F00D);
        txn(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_BEEF, 0, 0, m_rd, m_err, d_rd);
        txn(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_half_store", d_rd, 32'hBEEF_F00D);

        txn(1'b1, 32'h1004, 2'b10, 1'b0, 32'h0BAD_F00D, 0, 0, m_rd, m_err, d_rd);
        txn(1'b0, 32'h0004, 2'b10, 1'b0, 32'h0, 0, 0, m_rd, m_err, d_rd);
        check("lit_wrap", d_rd, 32'h0BAD_F00D);
        txn(1'b0, 32'h1006, 2'b01, 1'b1, 32'h0, 2, 0, m_rd, m_err, d_rd);
        check("lit_uhalf_wrap", d_rd, 32'h0000_0BAD);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
